// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU controller and datapath
//
// Purpose: accepts a multiply or divide from EX, stalls the pipeline while it
// runs, then writes the 64-bit result to HI/LO with a one-cycle strobe.
// Optional feature macro: MULDIV_EARLY_OUT_EN (divide early-out when the
// divisor magnitude exceeds the dividend magnitude).
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE
//   op[1:0]    in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a[31:0] in  rs operand (multiplicand / dividend)
//   src_b[31:0] in  rt operand (multiplier / divisor)
//   flush      in   cancels the operation in flight
//   stall_req  out  pipeline stall request
//   done       out  one-cycle result-valid pulse
//   hilo_we    out  HI/LO write enable (same as done)
//   hi[31:0]   out  product[63:32] or remainder
//   lo[31:0]   out  product[31:0] or quotient

module muldiv_ctrl #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_ITERS  = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall_req,
   output logic        done,
   output logic        hilo_we,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES);
   localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] work_q, work_d;       // product, or {remainder, quotient}
   logic [31:0] divisor_q, divisor_d; // divisor magnitude
   logic [31:0] a_q, a_d;             // raw src_a for div-by-zero / early-out
   logic        div_q, div_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        early_q, early_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   // Load-time operand conditioning
   logic        signed_div;
   logic [31:0] mag_a, mag_b;
   logic [63:0] ext_a, ext_b, prod;
   logic        early_out;

   assign signed_div = (op == 2'b10);
   assign mag_a = (signed_div && src_a[31]) ? (32'd0 - src_a) : src_a;
   assign mag_b = (signed_div && src_b[31]) ? (32'd0 - src_b) : src_b;

   // Low 64 bits of a 64x64 product of the extended operands are the correct
   // signed or unsigned 32x32 product.
   assign ext_a = {(op[0] ? 32'd0 : {32{src_a[31]}}), src_a};
   assign ext_b = {(op[0] ? 32'd0 : {32{src_b[31]}}), src_b};
   assign prod  = ext_a * ext_b;

`ifdef MULDIV_EARLY_OUT_EN
   assign early_out = (mag_b != 32'd0) && (mag_b > mag_a);
`else
   assign early_out = 1'b0;
`endif

   // One restoring step: shift {rem,quo} left, trial-subtract the divisor
   // from the 33-bit shifted remainder, keep the difference if non-negative.
   logic [32:0] rem_sh, trial;
   logic [63:0] step_work;

   assign rem_sh    = work_q[63:31];
   assign trial     = rem_sh - {1'b0, divisor_q};
   assign step_work = trial[32] ? {work_q[62:0], 1'b0}
                                : {trial[31:0], work_q[30:0], 1'b1};

   // Sign fix applied in FIX
   logic [31:0] quo_fix, rem_fix;
   assign quo_fix = neg_quo_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
   assign rem_fix = neg_rem_q ? (32'd0 - work_q[63:32]) : work_q[63:32];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      a_d       = a_q;
      div_d     = div_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      early_d   = early_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               cnt_d   = 6'd0;
               a_d     = src_a;
               div_d   = op[1];
               early_d = 1'b0;
               if (!op[1]) begin
                  work_d  = prod;
                  state_d = S_MUL;
               end else begin
                  work_d    = {32'd0, mag_a};
                  divisor_d = mag_b;
                  neg_quo_d = signed_div && (src_a[31] ^ src_b[31]);
                  neg_rem_d = signed_div && src_a[31];
                  state_d   = S_DIV;
                  // Early-out still spends one DIV edge so done lands two
                  // edges after load; the step result is discarded in FIX.
                  if (early_out) begin
                     early_d = 1'b1;
                     cnt_d   = DIV_LAST - 6'd1;
                  end
               end
            end
         end
         S_MUL: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q + 6'd1 == MUL_LAST) begin
               state_d = S_FIX;
            end
         end
         S_DIV: begin
            work_d = step_work;
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q + 6'd1 == DIV_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
            done_d  = 1'b1;
            if (!div_q) begin
               hi_d = work_q[63:32];
               lo_d = work_q[31:0];
            end else if (divisor_q == 32'd0) begin
               hi_d = a_q;
               lo_d = 32'hFFFF_FFFF;
            end else if (early_q) begin
               hi_d = a_q;
               lo_d = 32'd0;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flush cancels from any state: no result, hi/lo untouched.
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = 6'd0;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         work_q    <= 64'd0;
         divisor_q <= 32'd0;
         a_q       <= 32'd0;
         div_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         early_q   <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         a_q       <= a_d;
         div_q     <= div_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         early_q   <= early_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Stall from the issue cycle; dropped in FIX so the instruction advances
   // with its result, and dropped immediately on flush.
   assign stall_req = !flush && (((state_q == S_IDLE) && start) ||
                                 (state_q == S_MUL) || (state_q == S_DIV));
   assign done      = done_q;
   assign hilo_we   = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle controller and iterative datapath for the HI/LO-writing instructions MULT, MULTU, DIV and DIVU.
- Sits beside the ALU in EX. It accepts an operation when the decoder has classified the instruction into one of these ALU ops.
- Holds a pipeline stall while the operation runs, then presents the 64-bit result with a one-cycle HI/LO write strobe.
- A late exception or ERET in the pipeline can flush it at any time.

Parameters:
- MUL_CYCLES, default 2. Number of wait cycles after a multiply is loaded before the result is written. Legal range 1..8.
- DIV_ITERS, default 32. Number of restoring-division iterations. Fixed at 32 for this ISA; it is a parameter only for bench acceleration.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand (multiplicand or dividend)
- src_b  in  32  rt operand (multiplier or divisor)
- flush  in  1  cancels the operation in flight
- stall_req  out  1  pipeline stall request
- done  out  1  one-cycle result-valid pulse
- hilo_we  out  1  HI/LO write enable; equal to done
- hi  out  32  result high word (product[63:32] or remainder)
- lo  out  32  result low word (product[31:0] or quotient)

Behaviour:
- Reset (async, resetn=0): state=IDLE; all counters 0; stall_req=0, done=0, hilo_we=0, hi=0, lo=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, on start=1 and flush=0, at load edge E0:
  - Latch op.
  - MULT/MULTU: register the full 64-bit product (signed or unsigned) into the working register; go to MUL.
  - DIV/DIVU: store operand magnitudes (absolute values for DIV), sign of quotient (a^b), sign of remainder (a); go to DIV.
- stall_req = start in IDLE (combinational), OR state is MUL or DIV. Its purpose is to stall from the issue cycle onward.
- MUL: counter runs 1..MUL_CYCLES. On the last count go to FIX. Latency: done high in the cycle after edge E0+MUL_CYCLES+1.
- DIV: one restoring step per edge: shift the remainder:quotient pair, trial-subtract, set the quotient bit. After DIV_ITERS steps go to FIX. Latency: done high after edge E0+DIV_ITERS+1.
- FIX, one edge: apply sign fix for DIV (negate quotient and/or remainder as required), load hi/lo, assert done=hilo_we=1 for exactly one cycle, return to IDLE. stall_req=0 in FIX, so the instruction advances with its result.
- hi and lo hold their values until the next FIX; they are not cleared by flush.
- Divide by zero: full iteration count still runs. Result is lo=32'hFFFFFFFF, hi=src_a. No sign fix applies to this case.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is 32-bit wrap; no trap.
- flush=1 in any state: next edge goes to IDLE. No done, no hi/lo update. stall_req drops in the same cycle that flush is seen.
- start and flush asserted together in IDLE: flush wins and nothing is loaded.
- start while not IDLE: ignored. No queuing.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: for DIV/DIVU, if the divisor magnitude is greater than the dividend magnitude at load (divisor nonzero), skip DIV and go straight to FIX. Result: quotient=0, remainder=src_a. done follows 2 edges after E0.
- Undefined: all divides take the full DIV_ITERS+1 latency.

Test Plan:
- MULT, src_a=0xFFFFFFFE (-2), src_b=3, MUL_CYCLES=2 → done exactly once, 3 edges after load; hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_req high from the start cycle through the MUL state.
- MULTU, src_a=0xFFFFFFFF, src_b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV, src_a=-7 (0xFFFFFFF9), src_b=2 → done 33 edges after load; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with the same operands → lo=0x7FFFFFFC, hi=1.
- DIV, src_a=0x80000000, src_b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- DIVU 100/7 started, flush pulsed at iteration 10 → state IDLE next edge; no done; hi/lo keep the prior values. A new start the following cycle completes normally with lo=14, hi=2.
- With MULDIV_EARLY_OUT_EN: DIVU 3/10 → done 2 edges after load, lo=0, hi=3. Without the macro → 33 edges, same values.
